// File: rtl/defines_pkg.sv
// rtl/defines_pkg.sv - SPU opcode set, lane-width constants, even-pipe entry type and helpers.
package defines_pkg;

  localparam int WORD     = 32;
  localparam int HALFWORD = 16;

  localparam int EVEN_ADDR_WD = 7;
  localparam int EVEN_DATA_WD = 128;

  typedef enum logic [6:0] {
    NOP,
    LNOP,
    LQD,
    STQD,
    BR,
    XOR,
    ILH,
    ILA,
    IL,
    AH,
    AHI,
    A,
    AI,
    SFH,
    SFHI,
    SF,
    SFI,
    SHLHI,
    SHL,
    SHLI,
    ROT,
    ROTI
  } Opcodes;

  typedef struct packed {
    logic                    valid;
    logic [EVEN_ADDR_WD-1:0] addr;
    logic [EVEN_DATA_WD-1:0] data;
  } even_entry_t;

  function automatic logic even_is_known(input Opcodes op);
    case (op)
      ILH, ILA, IL, AH, AHI, A, AI, SFH, SFHI, SF, SFI,
      SHLHI, SHL, SHLI, ROT, ROTI: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  // A count of zero shifts right by the full width, which yields 0 and passes v through.
  function automatic logic [WORD-1:0] rotl_word(input logic [WORD-1:0] v, input logic [4:0] n);
    return (v << n) | (v >> (6'd32 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/even_alu.sv
// rtl/even_alu.sv - combinational even-pipe datapath: opcode, operands and immediates to {known, result}.
module even_alu
  import defines_pkg::*;
#(
  parameter int REG_DATA_WD = 128
) (
  input  Opcodes                 opcode,
  input  logic [REG_DATA_WD-1:0] in_RA,
  input  logic [REG_DATA_WD-1:0] in_RB,
  input  logic [6:0]             in_I7,
  input  logic [9:0]             in_I10,
  input  logic [15:0]            in_I16,
  input  logic [17:0]            in_I18,
  output logic                   known,
  output logic [REG_DATA_WD-1:0] result
);

  localparam int NW = REG_DATA_WD / WORD;
  localparam int NH = 2 * NW;

  logic [WORD-1:0]     i10_w;
  logic [HALFWORD-1:0] i10_h;
  logic                unused_i7_msb;

  logic [REG_DATA_WD-1:0] add_w, addi_w, sf_w, sfi_w, shl_w, shli_w, rot_w, roti_w;
  logic [REG_DATA_WD-1:0] ah_h, ahi_h, sfh_h, sfhi_h, shlhi_h;

  assign i10_w         = {{(WORD-10){in_I10[9]}}, in_I10};
  assign i10_h         = {{(HALFWORD-10){in_I10[9]}}, in_I10};
  assign unused_i7_msb = in_I7[6];

  for (genvar w = 0; w < NW; w++) begin : g_word
    logic [WORD-1:0] ra, rb;
    assign ra = in_RA[w*WORD +: WORD];
    assign rb = in_RB[w*WORD +: WORD];

    assign add_w [w*WORD +: WORD] = ra + rb;
    assign addi_w[w*WORD +: WORD] = ra + i10_w;
    assign sf_w  [w*WORD +: WORD] = ra - rb;
    assign sfi_w [w*WORD +: WORD] = ra - i10_w;
    assign shl_w [w*WORD +: WORD] = rb[5]    ? '0 : (ra << rb[4:0]);
    assign shli_w[w*WORD +: WORD] = in_I7[5] ? '0 : (ra << in_I7[4:0]);
    assign rot_w [w*WORD +: WORD] = rotl_word(ra, rb[4:0]);
    assign roti_w[w*WORD +: WORD] = rotl_word(ra, in_I7[4:0]);
  end

  for (genvar h = 0; h < NH; h++) begin : g_half
    logic [HALFWORD-1:0] ra, rb;
    assign ra = in_RA[h*HALFWORD +: HALFWORD];
    assign rb = in_RB[h*HALFWORD +: HALFWORD];

    assign ah_h   [h*HALFWORD +: HALFWORD] = ra + rb;
    assign ahi_h  [h*HALFWORD +: HALFWORD] = ra + i10_h;
    assign sfh_h  [h*HALFWORD +: HALFWORD] = ra - rb;
    assign sfhi_h [h*HALFWORD +: HALFWORD] = ra - i10_h;
    assign shlhi_h[h*HALFWORD +: HALFWORD] = in_I7[4] ? '0 : (ra << in_I7[3:0]);
  end

  assign known = even_is_known(opcode);

  always_comb begin
    result = '0;
    case (opcode)
      ILH:     result = {NH{in_I16}};
      ILA:     result = {NW{{14'b0, in_I18}}};
      IL:      result = {NW{{{HALFWORD{in_I16[15]}}, in_I16}}};
      AH:      result = ah_h;
      AHI:     result = ahi_h;
      A:       result = add_w;
      AI:      result = addi_w;
      SFH:     result = sfh_h;
      SFHI:    result = sfhi_h;
      SF:      result = sf_w;
      SFI:     result = sfi_w;
      SHLHI:   result = shlhi_h;
      SHL:     result = shl_w;
      SHLI:    result = shli_w;
      ROT:     result = rot_w;
      ROTI:    result = roti_w;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/even_pipe_gen.sv
// rtl/even_pipe_gen.sv - even pipe: issue, DEPTH-stage result pipeline, flush, forwarding taps.
// Optional perf counters (issued/killed/retired) are built when EVEN_PIPE_PERF_CNT_EN is defined.
module even_pipe_gen
  import defines_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int REG_ADDR_WD  = 7,
  parameter int REG_DATA_WD  = 128,
  parameter int FWD_LAT      = 2,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  Opcodes                       opcode,
  input  logic [REG_DATA_WD-1:0]       in_RA,
  input  logic [REG_DATA_WD-1:0]       in_RB,
  input  logic [6:0]                   in_I7,
  input  logic [9:0]                   in_I10,
  input  logic [15:0]                  in_I16,
  input  logic [17:0]                  in_I18,
  input  logic [REG_ADDR_WD-1:0]       in_RT_addr,
  input  logic                         flush,
  output logic [DEPTH-1:0]             fwd_valid,
  output logic [DEPTH-1:0]             fwd_ready,
  output logic [DEPTH*REG_ADDR_WD-1:0] fwd_addr,
  output logic [DEPTH*REG_DATA_WD-1:0] fwd_data,
`ifdef EVEN_PIPE_PERF_CNT_EN
  output logic [31:0]                  perf_issued,
  output logic [31:0]                  perf_killed,
  output logic [31:0]                  perf_retired,
`endif
  output logic                         wb_en,
  output logic [REG_ADDR_WD-1:0]       wb_addr,
  output logic [REG_DATA_WD-1:0]       wb_data
);

  typedef struct packed {
    logic                   valid;
    logic [REG_ADDR_WD-1:0] addr;
    logic [REG_DATA_WD-1:0] data;
  } stage_t;

  stage_t stage_q [DEPTH];
  stage_t stage_d [DEPTH];

  logic                   alu_known;
  logic [REG_DATA_WD-1:0] alu_result;
  logic                   issue_ok;

  even_alu #(
    .REG_DATA_WD (REG_DATA_WD)
  ) u_alu (
    .opcode (opcode),
    .in_RA  (in_RA),
    .in_RB  (in_RB),
    .in_I7  (in_I7),
    .in_I10 (in_I10),
    .in_I16 (in_I16),
    .in_I18 (in_I18),
    .known  (alu_known),
    .result (alu_result)
  );

  assign issue_ok = issue_valid & alu_known;

  // Invalid slots are kept all-zero so consumers never see stale addr/data.
  // Flush kills the issuing op and whatever currently sits in stages 1..FLUSH_STAGES.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = '0;
    end
    if (issue_ok && !flush) begin
      stage_d[0].valid = 1'b1;
      stage_d[0].addr  = in_RT_addr;
      stage_d[0].data  = alu_result;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (stage_q[k-1].valid && !(flush && (k <= FLUSH_STAGES))) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_fwd
    assign fwd_valid[k]                             = stage_q[k].valid;
    assign fwd_addr[k*REG_ADDR_WD +: REG_ADDR_WD]   = stage_q[k].addr;
    assign fwd_data[k*REG_DATA_WD +: REG_DATA_WD]   = stage_q[k].data;
    if (k + 1 >= FWD_LAT) begin : g_rdy
      assign fwd_ready[k] = stage_q[k].valid;
    end else begin : g_nrdy
      assign fwd_ready[k] = 1'b0;
    end
  end

  assign wb_en   = stage_q[DEPTH-1].valid;
  assign wb_addr = stage_q[DEPTH-1].addr;
  assign wb_data = stage_q[DEPTH-1].data;

`ifdef EVEN_PIPE_PERF_CNT_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] killed_q, killed_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] kill_cnt;

  always_comb begin
    kill_cnt = '0;
    if (flush) begin
      kill_cnt = {31'b0, issue_ok};
      for (int k = 0; k < FLUSH_STAGES; k++) begin
        kill_cnt = kill_cnt + {31'b0, stage_q[k].valid};
      end
    end
    issued_d  = issued_q + {31'b0, issue_ok};
    killed_d  = killed_q + kill_cnt;
    retired_d = retired_q + {31'b0, stage_q[DEPTH-1].valid};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q  <= '0;
      killed_q  <= '0;
      retired_q <= '0;
    end else begin
      issued_q  <= issued_d;
      killed_q  <= killed_d;
      retired_q <= retired_d;
    end
  end

  assign perf_issued  = issued_q;
  assign perf_killed  = killed_q;
  assign perf_retired = retired_q;
`endif

endmodule
